dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage and an external requester (program loader / debug port).
- Registers the granted command and drives the dmem for ACC_LAT cycles.
- Returns registered read data to the owning requester.
- Generates the MEM-stage stall and an anti-starvation slot for the external port.

Parameters:
- ACC_LAT, 1, cycles one dmem access occupies the memory (legal 1..4).
- STARVE_MAX, 4, consecutive contested MEM wins before the external port gets a forced slot (legal 1..15).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous reset, active-high
- mem_req  in  1  MEM stage requests an access this cycle
- mem_wena  in  1  1=store, 0=load
- mem_w_cs  in  2  store width select, passed to dmem
- mem_r_cs  in  2  load width select, passed to dmem
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data
- mem_stall  out  1  MEM request not accepted this cycle; pipeline must hold
- mem_rdata  out  32  load data for MEM stage
- mem_rvalid  out  1  one-cycle pulse, mem_rdata valid
- ext_req  in  1  external requester access request; held until ext_gnt
- ext_wena  in  1  1=store, 0=load
- ext_w_cs  in  2  store width select
- ext_r_cs  in  2  load width select
- ext_addr  in  32  byte address
- ext_wdata  in  32  store data
- ext_gnt  out  1  one-cycle pulse, ext request accepted
- ext_rdata  out  32  load data for external port
- ext_rvalid  out  1  one-cycle pulse, ext_rdata valid
- dmem_ena  out  1  dmem enable
- dmem_wena  out  1  dmem write enable
- dmem_w_cs  out  2  dmem store width select
- dmem_r_cs  out  2  dmem load width select
- dmem_addr  out  32  dmem address
- dmem_wdata  out  32  dmem write data
- dmem_rdata  in  32  dmem read data (combinational from dmem_addr)

Behaviour:
- Reset (async): state=IDLE; lat_cnt=0; starve_cnt=0; all dmem_* outputs, rdata registers, rvalid, ext_gnt = 0. An in-flight access is abandoned; dmem_ena drops immediately.
- States: IDLE, BUSY. Command register {owner, wena, w_cs, r_cs, addr, wdata} drives the dmem_* outputs directly (registered, no comb path from req to dmem).
- Grant point: state==IDLE, or state==BUSY with lat_cnt==ACC_LAT-1 (back-to-back; ACC_LAT=1 gives one access per cycle).
- Winner at a grant point:
  - ext wins if ext_req && (starve_cnt==STARVE_MAX || !mem_req).
  - Otherwise mem wins if mem_req.
  - No request: go to IDLE, dmem_ena=0.
- On grant: load the command register; state=BUSY; lat_cnt=0; dmem_ena=1 from the next cycle for ACC_LAT cycles. lat_cnt increments each BUSY cycle.
- mem_stall = mem_req && !(grant point && mem wins). Combinational.
- ext_gnt = 1 in the grant cycle when ext wins. ext_req may drop the cycle after ext_gnt.
- Read return: on the last BUSY cycle of a load, capture dmem_rdata into the owner's rdata register; owner's rvalid pulses the following cycle. Latency from accept cycle T: dmem active T+1..T+ACC_LAT, rvalid at T+ACC_LAT+1. Stores produce no rvalid.
- rdata registers hold their value until the next load of the same owner.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when mem wins while ext_req=1.
  - Clears when ext wins or ext_req=0 at a grant point.
- Simultaneous mem_req and ext_req with starve_cnt<STARVE_MAX: mem wins, ext waits.
- Forced ext slot: mem_stall=1 for exactly one grant point.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0]: counts cycles with mem_stall=1.
  - Adds output perf_ext_cnt [31:0]: counts ext grants.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ACC_LAT=1, mem load addr 0x10, dmem holds 0xDEADBEEF -> mem_stall=0 at T; dmem_ena=1, dmem_addr=0x10 at T+1; mem_rvalid=1, mem_rdata=0xDEADBEEF at T+2.
- ACC_LAT=3, two back-to-back mem stores to 0x0 and 0x4 -> second held with mem_stall=1 for 2 cycles; dmem_ena continuous for 6 cycles; no rvalid.
- STARVE_MAX=4, ACC_LAT=1, mem_req and ext_req held continuously -> mem wins 4 grants, ext_gnt pulses on the 5th with mem_stall=1 that cycle, then mem resumes; repeats every 5 cycles.
- mem_req=0, ext load addr 0x20 -> ext_gnt at T, ext_rvalid at T+ACC_LAT+1 with dmem data; mem_rvalid stays 0.
- ACC_LAT=4, rst asserted mid-access (lat_cnt=2) -> dmem_ena=0 same cycle; no rvalid after release; next mem_req is granted immediately from IDLE.
- With DMEM_ARB_PERF_EN, the forced-slot scenario run for 10 cycles -> perf_ext_cnt=2, perf_stall_cnt=2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage and
// an external requester (loader / debug). The granted command is registered
// and drives the dmem for ACC_LAT cycles; load data returns registered to the
// owning side. A starvation counter forces an external slot after STARVE_MAX
// consecutive contested MEM wins.
// Optional build macro: DMEM_ARB_PERF_EN adds perf_stall_cnt / perf_ext_cnt.
module dmem_arbiter #(
  parameter int unsigned ACC_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wena,
  input  logic [1:0]  mem_w_cs,
  input  logic [1:0]  mem_r_cs,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  input  logic        ext_req,
  input  logic        ext_wena,
  input  logic [1:0]  ext_w_cs,
  input  logic [1:0]  ext_r_cs,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic [31:0] ext_rdata,
  output logic        ext_rvalid,
  output logic        dmem_ena,
  output logic        dmem_wena,
  output logic [1:0]  dmem_w_cs,
  output logic [1:0]  dmem_r_cs,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_ext_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [1:0] LAST = 2'(ACC_LAT - 1);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [0:0] state;
  logic [1:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       owner_ext;
  logic       grant_pt;
  logic       ext_win;
  logic       mem_win;
  logic       last_cycle;

  // Grant decision; reset blocks any grant so nothing is accepted while held.
  always_comb begin
    grant_pt   = !rst && ((state == IDLE) || (lat_cnt == LAST));
    ext_win    = grant_pt && ext_req && ((starve_cnt == SMAX) || !mem_req);
    mem_win    = grant_pt && mem_req && !ext_win;
    mem_stall  = mem_req && !mem_win;
    ext_gnt    = ext_win;
    last_cycle = (state == BUSY) && (lat_cnt == LAST);
  end

  // State, latency counter and the command register that drives the dmem.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      owner_ext  <= 1'b0;
      dmem_ena   <= 1'b0;
      dmem_wena  <= 1'b0;
      dmem_w_cs  <= '0;
      dmem_r_cs  <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (grant_pt) begin
      lat_cnt <= '0;
      if (ext_win) begin
        state      <= BUSY;
        owner_ext  <= 1'b1;
        dmem_ena   <= 1'b1;
        dmem_wena  <= ext_wena;
        dmem_w_cs  <= ext_w_cs;
        dmem_r_cs  <= ext_r_cs;
        dmem_addr  <= ext_addr;
        dmem_wdata <= ext_wdata;
      end else if (mem_win) begin
        state      <= BUSY;
        owner_ext  <= 1'b0;
        dmem_ena   <= 1'b1;
        dmem_wena  <= mem_wena;
        dmem_w_cs  <= mem_w_cs;
        dmem_r_cs  <= mem_r_cs;
        dmem_addr  <= mem_addr;
        dmem_wdata <= mem_wdata;
      end else begin
        state    <= IDLE;
        dmem_ena <= 1'b0;
      end
    end else begin
      lat_cnt <= 2'(lat_cnt + 2'd1);
    end
  end

  // Starvation tracking: counts contested MEM wins, saturating at STARVE_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_pt) begin
      if (ext_win || !ext_req) begin
        starve_cnt <= '0;
      end else if (mem_win && (starve_cnt != SMAX)) begin
        starve_cnt <= 4'(starve_cnt + 4'd1);
      end
    end
  end

  // Load return: capture on the last access cycle, pulse valid one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata  <= '0;
      mem_rvalid <= 1'b0;
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
      if (last_cycle && !dmem_wena) begin
        if (owner_ext) begin
          ext_rdata  <= dmem_rdata;
          ext_rvalid <= 1'b1;
        end else begin
          mem_rdata  <= dmem_rdata;
          mem_rvalid <= 1'b1;
        end
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Performance counters: stall cycles and external grants, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_ext_cnt   <= '0;
    end else begin
      if (mem_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ext_win)   perf_ext_cnt   <= perf_ext_cnt + 32'd1;
    end
  end
`endif

endmodule
